// File: rtl/calendar_ctrl.sv
// Calendar controller: day/month/year with edge-detected requests; CAL_LEAP_YEAR_EN enables Feb 29 on year[1:0]==0.
// Latency: request edge -> grant +1, day +2, month +3, year +4 cycles; busy while the FSM is out of IDLE.
// No backpressure: one pending flag per source; a repeat edge while still pending sets the sticky dropped flag.
module calendar_ctrl (
  input  logic       clk,
  input  logic       reset,
  input  logic       day_tick,
  input  logic       adj_day,
  input  logic       adj_month,
  output logic [4:0] day,
  output logic [3:0] month,
  output logic [6:0] year,
  output logic       end_of_month,
  output logic       end_of_year,
  output logic       busy,
  output logic       dropped
);
  typedef enum logic [2:0] {IDLE, DAY, MONTH, YEAR, CLAMP} state_t;

  state_t     state;
  logic [2:0] req_now, req_prev, req_edge, pend, grant;
  logic       month_adj;
  logic [4:0] feb_days, dim;

  assign req_now  = {adj_month, adj_day, day_tick};
  assign req_edge = req_now & ~req_prev;
  assign busy     = (state != IDLE);

`ifdef CAL_LEAP_YEAR_EN
  assign feb_days = (year[1:0] == 2'b00) ? 5'd29 : 5'd28;
`else
  assign feb_days = 5'd28;
`endif

  always_comb begin
    case (month)
      4'd2:                    dim = feb_days;
      4'd4, 4'd6, 4'd9, 4'd11: dim = 5'd30;
      default:                 dim = 5'd31;
    endcase
  end

  // Bit 0 day_tick, bit 1 adj_day, bit 2 adj_month; lowest index wins.
  always_comb begin
    grant = 3'b000;
    if (state == IDLE) begin
      if (pend[0])      grant = 3'b001;
      else if (pend[1]) grant = 3'b010;
      else if (pend[2]) grant = 3'b100;
    end
  end

  always_ff @(posedge clk) begin
    req_prev <= req_now;
    if (reset) begin
      state        <= IDLE;
      pend         <= 3'b000;
      month_adj    <= 1'b0;
      day          <= 5'd1;
      month        <= 4'd1;
      year         <= 7'd0;
      end_of_month <= 1'b0;
      end_of_year  <= 1'b0;
      dropped      <= 1'b0;
    end else begin
      pend         <= req_edge | (pend & ~grant);
      end_of_month <= 1'b0;
      end_of_year  <= 1'b0;
      if (|(req_edge & pend & ~grant))
        dropped <= 1'b1;

      case (state)
        IDLE: begin
          if (grant[0] || grant[1]) begin
            month_adj <= 1'b0;
            state     <= DAY;
          end else if (grant[2]) begin
            month_adj <= 1'b1;
            state     <= MONTH;
          end
        end
        DAY: begin
          if (day < dim) begin
            day   <= day + 5'd1;
            state <= IDLE;
          end else begin
            day   <= 5'd1;
            state <= MONTH;
          end
        end
        MONTH: begin
          if (month_adj) begin
            month <= (month == 4'd12) ? 4'd1 : month + 4'd1;
            state <= CLAMP;
          end else begin
            end_of_month <= 1'b1;
            if (month == 4'd12) begin
              month <= 4'd1;
              state <= YEAR;
            end else begin
              month <= month + 4'd1;
              state <= IDLE;
            end
          end
        end
        YEAR: begin
          end_of_year <= 1'b1;
          year        <= (year == 7'd99) ? 7'd0 : year + 7'd1;
          state       <= IDLE;
        end
        CLAMP: begin
          // dim here already reflects the month written in the previous cycle
          if (day > dim)
            day <= dim;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: doc/calendar_ctrl.md
CALENDAR_CTRL -- requirements
Module: calendar_ctrl

Interface
REQ-001 SHALL have port clk, input, 1, system clock; all state updates on its rising edge.
REQ-002 SHALL have port reset, input, 1, synchronous, active-high reset.
REQ-003 SHALL have port day_tick, input, 1, end-of-day level from time-of-day counter; rising edge = one day event.
REQ-004 SHALL have port adj_day, input, 1, user day-advance button (debounced); rising edge = one day event.
REQ-005 SHALL have port adj_month, input, 1, user month-advance button (debounced); rising edge = one month-adjust event.
REQ-006 SHALL have port day, output, 5, current day 1..31.
REQ-007 SHALL have port month, output, 4, current month 1..12.
REQ-008 SHALL have port year, output, 7, years since 2000, 0..99.
REQ-009 SHALL have port end_of_month, output, 1, one-cycle pulse on day-driven month rollover.
REQ-010 SHALL have port end_of_year, output, 1, one-cycle pulse on day-driven 12->1 wrap.
REQ-011 SHALL have port busy, output, 1, high whenever the FSM is not IDLE.
REQ-012 SHALL have port dropped, output, 1, sticky; set when an event edge arrives while that source is already pending.

Function
REQ-013 SHALL rising-edge-detect each request input against its own previous-cycle sample.
REQ-014 SHALL keep one pending flag per source; an edge sets it in any state; a grant clears it.
REQ-015 SHALL arbitrate in IDLE only, fixed priority day_tick > adj_day > adj_month, one grant per IDLE cycle.
REQ-016 SHALL implement FSM states IDLE, DAY, MONTH, YEAR, CLAMP.
REQ-017 SHALL on a day grant go IDLE->DAY; in DAY: if day < dim then day+1 and ->IDLE, else day=1 and ->MONTH.
REQ-018 SHALL in MONTH after a day carry: pulse end_of_month; if month==12 then month=1 and ->YEAR, else month+1 and ->IDLE.
REQ-019 SHALL in YEAR: pulse end_of_year; year=0 if year==99 else year+1; ->IDLE.
REQ-020 SHALL on an adj_month grant go IDLE->MONTH; in that MONTH: month wraps 12->1, year unchanged, no pulses; ->CLAMP.
REQ-021 SHALL in CLAMP set day=dim(new month, year) if day > dim, else leave day unchanged; ->IDLE.
REQ-022 SHALL compute dim as 31 (months 1,3,5,7,8,10,12), 30 (4,6,9,11), and 28/29 for February per REQ-027.
REQ-023 SHALL meet this latency: edge sampled at clock edge k sets pending at k; grant (IDLE->DAY) at k+1; day updated at k+2; month at k+3; year at k+4.
REQ-024 SHALL register end_of_month and end_of_year, each high exactly one cycle, in the cycle after the month or year register update.

Reset
REQ-025 SHALL on reset set day=1, month=1, year=0, state IDLE, all pending flags 0, end_of_month=0, end_of_year=0, busy=0, dropped=0; reset overrides any in-flight operation.
REQ-026 SHALL load previous-sample registers with the current inputs during reset, so an input held high across reset release produces no event.

Configuration
REQ-027 SHALL with macro CAL_LEAP_YEAR_EN defined give February 29 days when year[1:0]==0 (every 4th year is leap within 2000-2099), else 28; without the macro, February SHALL always have 28 days.

Verification
REQ-028 SHALL cover: reset, then day_tick edges until 31 Jan -> one more edge gives day=1, month=2; end_of_month pulses exactly once; busy spans k+1..k+3.
REQ-029 SHALL cover: state 31 Dec, year 99, then one day_tick edge -> 1 Jan, year 0; end_of_month and end_of_year each pulse once, one cycle apart.
REQ-030 SHALL cover: year 24, 28 Feb, then one day_tick edge -> 29 Feb with CAL_LEAP_YEAR_EN, 1 Mar without it.
REQ-031 SHALL cover: day_tick and adj_day edges in the same cycle -> day_tick is granted first, then adj_day; day advances by 2 in total; dropped stays 0.
REQ-032 SHALL cover: 31 Jan, then adj_month edge -> month=2, day=28 (non-leap), year unchanged, no end_of_month pulse; a second adj_day edge while adj_day is still pending -> dropped=1.
